// File: rtl/coax_rx_if.sv
// Line and decoded-word signals of the coax receiver.
// The slave side is the receiver; the master side drives the line and observes the outputs.
interface coax_rx_if;
    logic       rx;
    logic       active;
    logic [9:0] data;
    logic       data_strobe;
    logic       parity_error;
    logic       error;

    modport master (
        output rx,
        input  active, data, data_strobe, parity_error, error
    );

    modport slave (
        input  rx,
        output active, data, data_strobe, parity_error, error
    );
endinterface

// File: rtl/coax_rx.sv
// Manchester-coded coax receiver. It synchronizes the line and classifies the
// spacing between edges, then decodes the quiesce, code-violation, sync, data and parity framing.
module coax_rx #(
    parameter int CLOCKS_PER_BIT = 8
) (
    input  logic     clk,
    input  logic     reset_n,
    coax_rx_if.slave bus
);
    // state     | meaning
    // IDLE      | line quiet, waiting for a rising edge
    // QUIESCE   | counting quiesce 1 bits
    // CV_LOW    | low phase of the code violation (or boundary between quiesce bits)
    // CV_HIGH   | high phase of the code violation
    // SYNC      | expecting a sync 1 bit (or, after a word, 1 = next word / 0 = end)
    // DATA      | shifting in 10 data bits, MSB first
    // PARITY    | expecting the parity bit
    // END       | waiting for the closing violation or line timeout

    localparam int T_SHORT = CLOCKS_PER_BIT / 4;
    localparam int T_LONG  = (3 * CLOCKS_PER_BIT) / 4;
    localparam int T_VIOL  = (5 * CLOCKS_PER_BIT) / 4;
    localparam int T_SAT   = 2 * CLOCKS_PER_BIT;
    localparam int CW      = $clog2(T_SAT + 1);
    localparam logic [2:0] QUIESCE_MIN = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_QUIESCE, S_CV_LOW, S_CV_HIGH, S_SYNC, S_DATA, S_PARITY, S_END
    } state_t;

    typedef enum logic [1:0] {C_INVALID, C_SHORT, C_LONG, C_VIOL} iclass_t;

    state_t        state;
    logic [2:0]    sync_q;
    logic          edge_det;
    logic          rise;
    logic          timeout;
    logic [CW-1:0] interval;
    iclass_t       cls;
    logic          half;
    logic          bit_ok;
    logic          dec_err;
    logic [2:0]    qcnt;
    logic [3:0]    bit_idx;
    logic [9:0]    shreg;
    logic          word_seen;
    logic          active_q;
    logic          strobe_q;
    logic          perr_q;
    logic          error_q;
    logic [9:0]    data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[1:0], bus.rx};
    end

    assign edge_det = sync_q[1] ^ sync_q[2];
    assign rise     = sync_q[1];

    // Interval equals clocks between edges when sampled on the edge cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                        interval <= '0;
        else if (edge_det)                   interval <= CW'(1);
        else if (interval != CW'(T_SAT))     interval <= interval + CW'(1);
    end

    assign timeout = !edge_det && (interval == CW'(T_SAT - 1));

    always_comb begin
        cls = C_VIOL;
        if (interval < CW'(T_SHORT))      cls = C_INVALID;
        else if (interval < CW'(T_LONG))  cls = C_SHORT;
        else if (interval < CW'(T_VIOL))  cls = C_LONG;
    end

    // half = last edge was a bit boundary; a data bit lands on every mid-bit edge.
    always_comb begin
        bit_ok  = 1'b0;
        dec_err = 1'b0;
        if (timeout) begin
            dec_err = 1'b1;
        end else if (edge_det) begin
            if (half) begin
                if (cls == C_SHORT) bit_ok = 1'b1;
                else                dec_err = 1'b1;
            end else begin
                if (cls == C_LONG)        bit_ok = 1'b1;
                else if (cls != C_SHORT)  dec_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            half      <= 1'b0;
            qcnt      <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            word_seen <= 1'b0;
            active_q  <= 1'b0;
            strobe_q  <= 1'b0;
            perr_q    <= 1'b0;
            error_q   <= 1'b0;
            data_q    <= '0;
        end else begin
            strobe_q <= 1'b0;
            perr_q   <= 1'b0;
            error_q  <= 1'b0;
            if (error_q) active_q <= 1'b0;
            if (edge_det) half <= !half && (cls == C_SHORT);

            case (state)
                S_IDLE: begin
                    if (edge_det && rise) begin
                        state <= S_QUIESCE;
                        qcnt  <= '0;
                        half  <= 1'b0;
                    end
                end
                S_QUIESCE: begin
                    if (timeout) begin
                        state <= S_IDLE;
                    end else if (edge_det) begin
                        if (cls != C_SHORT) begin
                            state <= S_IDLE;
                        end else if (rise) begin
                            if (qcnt != 3'd7) qcnt <= qcnt + 3'd1;
                        end else if (qcnt >= QUIESCE_MIN) begin
                            state <= S_CV_LOW;
                        end
                    end
                end
                S_CV_LOW: begin
                    if (timeout) begin
                        state <= S_IDLE;
                    end else if (edge_det) begin
                        if (cls == C_VIOL) begin
                            state <= S_CV_HIGH;
                        end else if (cls == C_SHORT) begin
                            state <= S_QUIESCE;
                            if (qcnt != 3'd7) qcnt <= qcnt + 3'd1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_CV_HIGH: begin
                    if (timeout) begin
                        state <= S_IDLE;
                    end else if (edge_det) begin
                        if (cls == C_VIOL && !rise) begin
                            state     <= S_SYNC;
                            active_q  <= 1'b1;
                            half      <= 1'b1;
                            word_seen <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_SYNC: begin
                    if (dec_err) begin
                        error_q <= 1'b1;
                        state   <= S_IDLE;
                    end else if (bit_ok) begin
                        if (rise) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end else if (word_seen) begin
                            state <= S_END;
                        end else begin
                            error_q <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (dec_err) begin
                        error_q <= 1'b1;
                        state   <= S_IDLE;
                    end else if (bit_ok) begin
                        shreg <= {shreg[8:0], rise};
                        if (bit_idx == 4'd9) state <= S_PARITY;
                        else                 bit_idx <= bit_idx + 4'd1;
                    end
                end
                S_PARITY: begin
                    if (dec_err) begin
                        error_q <= 1'b1;
                        state   <= S_IDLE;
                    end else if (bit_ok) begin
                        data_q    <= shreg;
                        strobe_q  <= 1'b1;
                        perr_q    <= rise ^ (^shreg);
                        word_seen <= 1'b1;
                        state     <= S_SYNC;
                    end
                end
                S_END: begin
                    if (timeout) begin
                        state    <= S_IDLE;
                        active_q <= 1'b0;
                    end else if (edge_det) begin
                        if (cls == C_VIOL) begin
                            state    <= S_IDLE;
                            active_q <= 1'b0;
                        end else begin
                            error_q <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.active       = active_q;
    assign bus.data         = data_q;
    assign bus.data_strobe  = strobe_q;
    assign bus.parity_error = perr_q;
    assign bus.error        = error_q;
endmodule

// File: tb/tb_coax_rx.sv
// Bench for coax_rx: builds Manchester frames from a bit-level description and
// compares strobes, errors and activity against expectations derived from the frame content.
module tb_coax_rx;
    localparam int CPB = 8;
    localparam int HB  = CPB / 2;

    logic clk = 1'b0;
    logic reset_n;
    int   pass_cnt;
    int   total_cnt;

    coax_rx_if bus();

    coax_rx #(.CLOCKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int         n_err;
    int         n_act;
    logic [9:0] st_data [$];
    logic       st_perr [$];
    logic [9:0] words [4];
    logic       pbits [4];
    logic [9:0] model_data;

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (bus.data_strobe === 1'b1) begin
                st_data.push_back(bus.data);
                st_perr.push_back(bus.parity_error);
            end
            if (bus.error === 1'b1)  n_err++;
            if (bus.active === 1'b1) n_act++;
        end
    end

    task automatic seg(input logic lvl, input int n);
        bus.rx = lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        seg(~b, HB);
        seg(b, HB);
    endtask

    task automatic send_preamble(input int nq);
        seg(1'b0, 20);
        for (int i = 0; i < nq; i++) send_bit(1'b1);
        seg(1'b0, 12);
        seg(1'b1, 12);
        send_bit(1'b1);
    endtask

    task automatic send_word(input logic [9:0] w, input logic p);
        for (int i = 9; i >= 0; i--) send_bit(w[i]);
        send_bit(p);
    endtask

    task automatic send_frame(input int nq, input int nw);
        send_preamble(nq);
        for (int k = 0; k < nw; k++) begin
            send_word(words[k], pbits[k]);
            send_bit(logic'(k < nw - 1));
        end
        seg(1'b0, 40);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.rx  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (bus.active !== 1'b0) $display("FAIL reset_active: got %b expected 0", bus.active); else pass_cnt++;
        total_cnt++;
        if (bus.data !== 10'h000) $display("FAIL reset_data: got %h expected 000", bus.data); else pass_cnt++;
        total_cnt++;
        if (bus.data_strobe !== 1'b0) $display("FAIL reset_strobe: got %b expected 0", bus.data_strobe); else pass_cnt++;
        total_cnt++;
        if (bus.parity_error !== 1'b0) $display("FAIL reset_perr: got %b expected 0", bus.parity_error); else pass_cnt++;
        total_cnt++;
        if (bus.error !== 1'b0) $display("FAIL reset_error: got %b expected 0", bus.error); else pass_cnt++;
        reset_n = 1'b1;
        seg(1'b0, 30);
        total_cnt++;
        if (n_err !== 0 || n_act !== 0) $display("FAIL idle_after_reset: got err=%0d act=%0d expected 0/0", n_err, n_act); else pass_cnt++;
    endtask

    task automatic test_good_frame();
        int s0, e0, a0;
        s0 = st_data.size(); e0 = n_err; a0 = n_act;
        words[0] = 10'h2A5;
        pbits[0] = ^words[0];
        send_frame(6, 1);
        total_cnt++;
        if (st_data.size() - s0 !== 1) $display("FAIL good_strobes: got %0d expected 1", st_data.size() - s0); else pass_cnt++;
        if (st_data.size() - s0 == 1) begin
            total_cnt++;
            if (st_data[s0] !== 10'h2A5) $display("FAIL good_data: got %h expected 2a5", st_data[s0]); else pass_cnt++;
            total_cnt++;
            if (st_perr[s0] !== 1'b0) $display("FAIL good_perr: got %b expected 0", st_perr[s0]); else pass_cnt++;
        end
        total_cnt++;
        if (n_err - e0 !== 0) $display("FAIL good_error: got %0d pulses expected 0", n_err - e0); else pass_cnt++;
        total_cnt++;
        if (n_act - a0 == 0) $display("FAIL good_active_rose: got 0 active cycles expected >0"); else pass_cnt++;
        total_cnt++;
        if (bus.active !== 1'b0) $display("FAIL good_active_end: got %b expected 0", bus.active); else pass_cnt++;
        model_data = 10'h2A5;
    endtask

    task automatic test_parity_error();
        int s0, e0;
        s0 = st_data.size(); e0 = n_err;
        words[0] = 10'h2A5;
        pbits[0] = ~(^words[0]);
        send_frame(6, 1);
        total_cnt++;
        if (st_data.size() - s0 !== 1) $display("FAIL perr_strobes: got %0d expected 1", st_data.size() - s0); else pass_cnt++;
        if (st_data.size() - s0 == 1) begin
            total_cnt++;
            if (st_perr[s0] !== 1'b1) $display("FAIL perr_flag: got %b expected 1", st_perr[s0]); else pass_cnt++;
            total_cnt++;
            if (st_data[s0] !== 10'h2A5) $display("FAIL perr_data: got %h expected 2a5", st_data[s0]); else pass_cnt++;
        end
        total_cnt++;
        if (bus.active !== 1'b0 || n_err - e0 !== 0) $display("FAIL perr_end: got active=%b err=%0d expected 0/0", bus.active, n_err - e0); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int s0, e0;
        s0 = st_data.size(); e0 = n_err;
        words[0] = 10'h001; pbits[0] = ^words[0];
        words[1] = 10'h3FF; pbits[1] = ^words[1];
        send_frame(6, 2);
        total_cnt++;
        if (st_data.size() - s0 !== 2) $display("FAIL b2b_strobes: got %0d expected 2", st_data.size() - s0); else pass_cnt++;
        if (st_data.size() - s0 == 2) begin
            total_cnt++;
            if (st_data[s0] !== 10'h001 || st_perr[s0] !== 1'b0) $display("FAIL b2b_word0: got %h/%b expected 001/0", st_data[s0], st_perr[s0]); else pass_cnt++;
            total_cnt++;
            if (st_data[s0+1] !== 10'h3FF || st_perr[s0+1] !== 1'b0) $display("FAIL b2b_word1: got %h/%b expected 3ff/0", st_data[s0+1], st_perr[s0+1]); else pass_cnt++;
        end
        total_cnt++;
        if (n_err - e0 !== 0 || bus.active !== 1'b0) $display("FAIL b2b_end: got err=%0d active=%b expected 0/0", n_err - e0, bus.active); else pass_cnt++;
        model_data = 10'h3FF;
    endtask

    task automatic test_timeout();
        int s0, e0;
        logic [9:0] w;
        s0 = st_data.size(); e0 = n_err;
        w = 10'h2C3;
        send_preamble(6);
        for (int i = 9; i >= 6; i--) send_bit(w[i]);
        seg(w[6], 3 * CPB);
        seg(1'b0, 40);
        total_cnt++;
        if (n_err - e0 !== 1) $display("FAIL timeout_error: got %0d pulses expected 1", n_err - e0); else pass_cnt++;
        total_cnt++;
        if (st_data.size() - s0 !== 0) $display("FAIL timeout_strobe: got %0d expected 0", st_data.size() - s0); else pass_cnt++;
        total_cnt++;
        if (bus.active !== 1'b0) $display("FAIL timeout_active: got %b expected 0", bus.active); else pass_cnt++;
        total_cnt++;
        if (bus.data !== model_data) $display("FAIL timeout_data_hold: got %h expected %h", bus.data, model_data); else pass_cnt++;
    endtask

    task automatic test_short_quiesce();
        int s0, e0, a0;
        s0 = st_data.size(); e0 = n_err; a0 = n_act;
        words[0] = 10'h2A5; pbits[0] = ^words[0];
        send_frame(3, 1);
        total_cnt++;
        if (n_act - a0 !== 0) $display("FAIL shortq_active: got %0d active cycles expected 0", n_act - a0); else pass_cnt++;
        total_cnt++;
        if (st_data.size() - s0 !== 0 || n_err - e0 !== 0) $display("FAIL shortq_outputs: got strobes=%0d err=%0d expected 0/0", st_data.size() - s0, n_err - e0); else pass_cnt++;
    endtask

    task automatic test_reset_mid_word();
        int s0, e0;
        logic [9:0] w;
        w = 10'h2C3;
        send_preamble(6);
        for (int i = 9; i >= 6; i--) send_bit(w[i]);
        seg(~w[5], 2);
        total_cnt++;
        if (bus.active !== 1'b1) $display("FAIL rstmid_active_before: got %b expected 1", bus.active); else pass_cnt++;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({bus.active, bus.data_strobe, bus.parity_error, bus.error} !== 4'b0000 || bus.data !== 10'h000)
            $display("FAIL rstmid_clear: got act=%b stb=%b perr=%b err=%b data=%h expected all 0",
                     bus.active, bus.data_strobe, bus.parity_error, bus.error, bus.data);
        else pass_cnt++;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_data = 10'h000;
        s0 = st_data.size(); e0 = n_err;
        seg(1'b0, 40);
        total_cnt++;
        if (st_data.size() - s0 !== 0 || n_err - e0 !== 0) $display("FAIL rstmid_quiet: got strobes=%0d err=%0d expected 0/0", st_data.size() - s0, n_err - e0); else pass_cnt++;
        words[0] = 10'h15A; pbits[0] = ^words[0];
        send_frame(6, 1);
        total_cnt++;
        if (st_data.size() - s0 !== 1) $display("FAIL rstmid_strobes: got %0d expected 1", st_data.size() - s0); else pass_cnt++;
        total_cnt++;
        if (bus.data !== 10'h15A || n_err - e0 !== 0) $display("FAIL rstmid_frame: got data=%h err=%0d expected 15a/0", bus.data, n_err - e0); else pass_cnt++;
        model_data = 10'h15A;
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 20; f++) begin
            int nq, nw, s0, e0, a0, exp_n;
            logic exp_act;
            logic [9:0] exp_w [$];
            logic exp_p [$];
            nq = $urandom_range(2, 8);
            nw = $urandom_range(1, 3);
            for (int k = 0; k < nw; k++) begin
                words[k] = 10'($urandom);
                pbits[k] = 1'($urandom);
            end
            // A message starts only after at least five quiesce bits.
            exp_act = (nq >= 5);
            if (exp_act) begin
                for (int k = 0; k < nw; k++) begin
                    exp_w.push_back(words[k]);
                    exp_p.push_back(pbits[k] != (^words[k]));
                end
            end
            exp_n = exp_w.size();
            s0 = st_data.size(); e0 = n_err; a0 = n_act;
            send_frame(nq, nw);
            total_cnt++;
            if (st_data.size() - s0 !== exp_n) $display("FAIL rand%0d_strobes: got %0d expected %0d", f, st_data.size() - s0, exp_n); else pass_cnt++;
            if (st_data.size() - s0 == exp_n) begin
                for (int k = 0; k < exp_n; k++) begin
                    total_cnt++;
                    if (st_data[s0+k] !== exp_w[k] || st_perr[s0+k] !== exp_p[k])
                        $display("FAIL rand%0d_word%0d: got %h/%b expected %h/%b", f, k, st_data[s0+k], st_perr[s0+k], exp_w[k], exp_p[k]);
                    else pass_cnt++;
                end
            end
            if (exp_n > 0) model_data = exp_w[exp_n-1];
            total_cnt++;
            if ((n_act - a0 > 0) !== exp_act) $display("FAIL rand%0d_active: got %0d active cycles expected active=%b", f, n_act - a0, exp_act); else pass_cnt++;
            total_cnt++;
            if (n_err - e0 !== 0 || bus.active !== 1'b0) $display("FAIL rand%0d_end: got err=%0d active=%b expected 0/0", f, n_err - e0, bus.active); else pass_cnt++;
            total_cnt++;
            if (bus.data !== model_data) $display("FAIL rand%0d_data_hold: got %h expected %h", f, bus.data, model_data); else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt   = 0;
        total_cnt  = 0;
        n_err      = 0;
        n_act      = 0;
        model_data = 10'h000;
        test_reset();
        test_good_frame();
        test_parity_error();
        test_back_to_back();
        test_timeout();
        test_short_quiesce();
        test_reset_mid_word();
        test_random_frames();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
